// File: rtl/bid_auction_scheduler.sv
// Four-way bid auction scheduler for one shared downstream resource.
// Each round latches requests and bids, picks one winner (starvation first,
// then highest affordable bid, then a lone requester), debits its credit
// balance and holds the grant until done or until the hold limit expires.
// Balances are refilled periodically and stored here.
module bid_auction_scheduler #(
    parameter int BID_W         = 4,
    parameter int BAL_W         = 10,
    parameter int INIT_BAL      = 512,
    parameter int REFILL_PERIOD = 64,
    parameter int REFILL_AMT    = 16,
    parameter int AGE_LIMIT     = 32,
    parameter int MAX_HOLD      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [BID_W-1:0] bid_0,
    input  logic [BID_W-1:0] bid_1,
    input  logic [BID_W-1:0] bid_2,
    input  logic [BID_W-1:0] bid_3,
    input  logic             done,
    input  logic [1:0]       bal_sel,
    output logic [3:0]       grant,
    output logic             grant_valid,
    output logic             timeout,
    output logic [3:0]       starving,
    output logic [BAL_W-1:0] bal_out
);

    localparam int EXT_W = BAL_W + 2;
    localparam int RC_W  = (REFILL_PERIOD > 2) ? $clog2(REFILL_PERIOD) : 1;
    localparam int HC_W  = $clog2(MAX_HOLD + 1);
    localparam logic [EXT_W-1:0] BAL_MAX = EXT_W'((1 << BAL_W) - 1);

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        GRANT
    } state_t;

    state_t           state_q;
    logic [3:0]       reqLatch_q;
    logic [BID_W-1:0] bidLatch_q [4];
    logic [BAL_W-1:0] bal_q      [4];
    logic [BAL_W-1:0] bal_d      [4];
    logic [EXT_W-1:0] balSum     [4];
    logic [5:0]       age_q      [4];
    logic [1:0]       lastWin_q;
    logic [3:0]       grant_q;
    logic             timeout_q;
    logic [HC_W-1:0]  hold_q;
    logic [RC_W-1:0]  refillCnt_q;
    logic [BID_W-1:0] bidIn      [4];

    logic             refillTick;
    logic             winValid;
    logic [1:0]       winIdx;
    logic [1:0]       scanIdx;
    logic             starveFound;
    logic [1:0]       starveIdx;
    logic [5:0]       starveAge;
    logic             eligFound;
    logic [1:0]       eligIdx;
    logic [BID_W-1:0] eligBid;
    logic [2:0]       reqCount;
    logic [1:0]       soloIdx;

    assign bidIn[0] = bid_0;
    assign bidIn[1] = bid_1;
    assign bidIn[2] = bid_2;
    assign bidIn[3] = bid_3;

    assign refillTick = (refillCnt_q == RC_W'(REFILL_PERIOD - 1));

    // Winner search walks the requesters in round-robin order starting after the last winner, so strict comparisons keep the earliest candidate on ties.
    always_comb begin
        scanIdx     = '0;
        starveFound = 1'b0;
        starveIdx   = '0;
        starveAge   = '0;
        eligFound   = 1'b0;
        eligIdx     = '0;
        eligBid     = '0;
        reqCount    = '0;
        soloIdx     = '0;
        for (int k = 0; k < 4; k++) begin
            scanIdx = lastWin_q + 2'(k + 1);
            if (reqLatch_q[scanIdx]) begin
                reqCount = reqCount + 3'd1;
                soloIdx  = scanIdx;
                if ((age_q[scanIdx] >= 6'(AGE_LIMIT)) &&
                    (!starveFound || (age_q[scanIdx] > starveAge))) begin
                    starveFound = 1'b1;
                    starveIdx   = scanIdx;
                    starveAge   = age_q[scanIdx];
                end
                if ((BAL_W'(bidLatch_q[scanIdx]) <= bal_q[scanIdx]) &&
                    (!eligFound || (bidLatch_q[scanIdx] > eligBid))) begin
                    eligFound = 1'b1;
                    eligIdx   = scanIdx;
                    eligBid   = bidLatch_q[scanIdx];
                end
            end
        end
        winValid = 1'b1;
        winIdx   = '0;
        if (starveFound) begin
            winIdx = starveIdx;
        end else if (eligFound) begin
            winIdx = eligIdx;
        end else if (reqCount == 3'd1) begin
            winIdx = soloIdx;
        end else begin
            winValid = 1'b0;
        end
    end

    // Next balance folds refill and the winner's debit into one widened sum, then clamps it to the representable range.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            balSum[i] = EXT_W'(bal_q[i])
                      + (refillTick ? EXT_W'(REFILL_AMT) : '0)
                      - (((state_q == RESOLVE) && winValid && (winIdx == 2'(i)))
                         ? EXT_W'(bidLatch_q[i]) : '0);
            if (balSum[i][EXT_W-1]) begin
                bal_d[i] = '0;
            end else if (balSum[i] > BAL_MAX) begin
                bal_d[i] = BAL_MAX[BAL_W-1:0];
            end else begin
                bal_d[i] = balSum[i][BAL_W-1:0];
            end
        end
    end

    // Round sequencing, credit bookkeeping, aging and the registered grant/timeout outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            reqLatch_q  <= '0;
            lastWin_q   <= 2'd3;
            grant_q     <= '0;
            timeout_q   <= 1'b0;
            hold_q      <= '0;
            refillCnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                bidLatch_q[i] <= '0;
                bal_q[i]      <= BAL_W'(INIT_BAL);
                age_q[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                bal_q[i] <= bal_d[i];
            end
            refillCnt_q <= refillTick ? '0 : refillCnt_q + RC_W'(1);
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 4'b0) begin
                        reqLatch_q <= req;
                        for (int i = 0; i < 4; i++) begin
                            bidLatch_q[i] <= req[i] ? bidIn[i] : '0;
                        end
                        state_q <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    for (int i = 0; i < 4; i++) begin
                        if (winValid && (winIdx == 2'(i))) begin
                            age_q[i] <= '0;
                        end else if (reqLatch_q[i]) begin
                            age_q[i] <= (age_q[i] == 6'd63) ? age_q[i] : age_q[i] + 6'd1;
                        end else begin
                            age_q[i] <= '0;
                        end
                    end
                    if (winValid) begin
                        grant_q   <= 4'b1 << winIdx;
                        lastWin_q <= winIdx;
                        hold_q    <= '0;
                        state_q   <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    if (done || (hold_q == HC_W'(MAX_HOLD - 1))) begin
                        grant_q   <= '0;
                        timeout_q <= ~done;
                        state_q   <= IDLE;
                    end else begin
                        hold_q <= hold_q + HC_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Starvation flags are a direct view of the age registers.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            starving[i] = (age_q[i] >= 6'(AGE_LIMIT));
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;
    assign bal_out     = bal_q[bal_sel];

endmodule

// File: tb/tb_bid_auction_scheduler.sv
// Testbench for bid_auction_scheduler.
module tb_bid_auction_scheduler;

    localparam int BID_W         = 4;
    localparam int BAL_W         = 10;
    localparam int INIT_BAL      = 512;
    localparam int REFILL_PERIOD = 64;
    localparam int REFILL_AMT    = 16;
    localparam int AGE_LIMIT     = 32;
    localparam int MAX_HOLD      = 16;
    localparam int BAL_TOP       = (1 << BAL_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = '0;
    logic [BID_W-1:0] bid_0 = '0;
    logic [BID_W-1:0] bid_1 = '0;
    logic [BID_W-1:0] bid_2 = '0;
    logic [BID_W-1:0] bid_3 = '0;
    logic             done = 1'b0;
    logic [1:0]       bal_sel = '0;
    logic [3:0]       grant;
    logic             grant_valid;
    logic             timeout;
    logic [3:0]       starving;
    logic [BAL_W-1:0] bal_out;

    always #5 clk = ~clk;

    bid_auction_scheduler #(
        .BID_W(BID_W), .BAL_W(BAL_W), .INIT_BAL(INIT_BAL),
        .REFILL_PERIOD(REFILL_PERIOD), .REFILL_AMT(REFILL_AMT),
        .AGE_LIMIT(AGE_LIMIT), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .bid_0(bid_0), .bid_1(bid_1), .bid_2(bid_2), .bid_3(bid_3),
        .done(done), .bal_sel(bal_sel),
        .grant(grant), .grant_valid(grant_valid), .timeout(timeout),
        .starving(starving), .bal_out(bal_out)
    );

    typedef struct {
        logic [3:0] req;
        int         b0, b1, b2, b3;
        int         doneAt;
        logic [3:0] expGrant;
        int         balSel;
        int         expBal;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int mBal   [4];
    int mAge   [4];
    int mDebit [4];
    int mLw;
    int cyc;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mBal[i]   = INIT_BAL;
            mAge[i]   = 0;
            mDebit[i] = 0;
        end
        mLw = 3;
        cyc = 0;
    endtask

    // Advance one clock (negedge to negedge) and apply refill plus pending debits.
    task automatic step();
        int v;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            v = mBal[i] + (((cyc % REFILL_PERIOD) == 0) ? REFILL_AMT : 0) - mDebit[i];
            if (v < 0) v = 0;
            if (v > BAL_TOP) v = BAL_TOP;
            mBal[i]   = v;
            mDebit[i] = 0;
        end
        @(negedge clk);
    endtask

    task automatic applyReset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        rst = 1'b0;
    endtask

    function automatic int rrDist(input int i);
        return (i - mLw + 3) % 4;
    endfunction

    function automatic int modelWinner(input logic [3:0] r, input int b[4]);
        int best = -1;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && mAge[i] >= AGE_LIMIT) begin
                if (best < 0 || mAge[i] > mAge[best] ||
                    (mAge[i] == mAge[best] && rrDist(i) < rrDist(best))) best = i;
            end
        end
        if (best >= 0) return best;
        for (int i = 0; i < 4; i++) begin
            if (r[i] && mBal[i] >= b[i]) begin
                if (best < 0 || b[i] > b[best] ||
                    (b[i] == b[best] && rrDist(i) < rrDist(best))) best = i;
            end
        end
        if (best >= 0) return best;
        if ($countones(r) == 1) begin
            for (int i = 0; i < 4; i++) if (r[i]) best = i;
        end
        return best;
    endfunction

    task automatic checkBal(input int sel, input int expected, input string name);
        bal_sel = 2'(sel);
        #1;
        checkOutput(name, int'(bal_out), expected);
    endtask

    // One full auction round; done is raised in grant cycle doneAt (0 = never).
    task automatic applyStimulus(input logic [3:0] r, input int b0, input int b1,
                                 input int b2, input int b3, input int doneAt,
                                 output logic [3:0] gotGrant, output int grantCycles,
                                 output int tmoSeen);
        int         b[4];
        int         w;
        int         sel;
        logic [3:0] expG;
        logic [3:0] expS;
        b = '{b0, b1, b2, b3};
        req   = r;
        bid_0 = BID_W'(b0);
        bid_1 = BID_W'(b1);
        bid_2 = BID_W'(b2);
        bid_3 = BID_W'(b3);
        done  = 1'b0;
        step();
        req   = 4'($urandom);
        bid_0 = BID_W'($urandom);
        bid_1 = BID_W'($urandom);
        bid_2 = BID_W'($urandom);
        bid_3 = BID_W'($urandom);
        w = modelWinner(r, b);
        if (w >= 0) begin
            mDebit[w] = b[w];
        end
        for (int i = 0; i < 4; i++) begin
            if (i == w) mAge[i] = 0;
            else if (r[i]) mAge[i] = (mAge[i] >= 63) ? 63 : mAge[i] + 1;
            else mAge[i] = 0;
        end
        if (w >= 0) mLw = w;
        step();
        req  = '0;
        expG = (w >= 0) ? 4'(1 << w) : 4'b0;
        for (int i = 0; i < 4; i++) expS[i] = (mAge[i] >= AGE_LIMIT);
        gotGrant    = grant;
        grantCycles = (grant != 4'b0) ? 1 : 0;
        tmoSeen     = 0;
        checkOutput("grant", int'(grant), int'(expG));
        checkOutput("grant_valid", int'(grant_valid), int'(w >= 0));
        checkOutput("starving", int'(starving), int'(expS));
        sel = (w >= 0) ? w : int'($urandom_range(0, 3));
        checkBal(sel, mBal[sel], "balAfterResolve");
        sel = int'($urandom_range(0, 3));
        checkBal(sel, mBal[sel], "balRandomSel");
        if (w >= 0) begin
            for (int k = 1; k <= MAX_HOLD; k++) begin
                if (k == doneAt) done = 1'b1;
                step();
                done = 1'b0;
                if (grant != 4'b0) grantCycles++;
                if (timeout) tmoSeen++;
                if (k == doneAt || k == MAX_HOLD) begin
                    checkOutput("grantRelease", int'(grant), 0);
                    checkOutput("timeoutPulse", int'(timeout), (k == doneAt) ? 0 : 1);
                    break;
                end else begin
                    checkOutput("grantHold", int'(grant), int'(expG));
                    checkOutput("timeoutIdle", int'(timeout), 0);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t       vecs[6];
        logic [3:0] g;
        int         gc;
        int         tm;
        int         bid;

        vecs[0] = '{4'b0001, 5, 0, 0, 0, 1, 4'b0001, 0, 507};
        vecs[1] = '{4'b1111, 3, 9, 9, 2, 2, 4'b0010, 1, 503};
        vecs[2] = '{4'b1111, 3, 9, 9, 2, 3, 4'b0100, 2, 503};
        vecs[3] = '{4'b1001, 7, 0, 0, 7, 1, 4'b1000, 3, 505};
        vecs[4] = '{4'b1001, 7, 0, 0, 7, 1, 4'b0001, 0, 500};
        vecs[5] = '{4'b0110, 0, 15, 4, 0, 1, 4'b0010, 1, 488};

        applyReset();
        checkOutput("resetGrant", int'(grant), 0);
        checkOutput("resetGrantValid", int'(grant_valid), 0);
        checkOutput("resetTimeout", int'(timeout), 0);
        checkOutput("resetStarving", int'(starving), 0);
        for (int s = 0; s < 4; s++) checkBal(s, INIT_BAL, "resetBal");

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].req, vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3,
                          vecs[v].doneAt, g, gc, tm);
            checkOutput($sformatf("vec%0d_grant", v), int'(g), int'(vecs[v].expGrant));
            checkBal(vecs[v].balSel, vecs[v].expBal, $sformatf("vec%0d_bal", v));
        end

        for (int n = 0; n < 40; n++) begin
            logic [3:0] r;
            r = 4'($urandom_range(0, 15));
            if (r == 4'b0) begin
                req = '0;
                step();
                checkOutput("idleGrant", int'(grant), 0);
            end else begin
                applyStimulus(r, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                              int'($urandom_range(0, MAX_HOLD + 2)), g, gc, tm);
            end
        end

        applyReset();
        for (int n = 1; n <= 32; n++) begin
            applyStimulus(4'b1001, 15, 0, 0, 1, 1, g, gc, tm);
            if (n == 31) checkOutput("notYetStarving3", int'(starving[3]), 0);
        end
        checkOutput("starving3", int'(starving[3]), 1);
        applyStimulus(4'b1001, 15, 0, 0, 1, 1, g, gc, tm);
        checkOutput("starveGrant", int'(g), 4'b1000);
        checkOutput("starve3Cleared", int'(starving[3]), 0);

        for (int n = 0; n < 100 && mBal[0] > 30; n++) begin
            applyStimulus(4'b0001, 15, 0, 0, 0, 1, g, gc, tm);
        end
        for (int n = 0; n < 2 * REFILL_PERIOD && (cyc % REFILL_PERIOD) != 1; n++) step();
        for (int n = 0; n < 10 && mBal[0] > 4; n++) begin
            bid = (mBal[0] - 4 > 15) ? 15 : mBal[0] - 4;
            applyStimulus(4'b0001, bid, 0, 0, 0, 1, g, gc, tm);
        end
        checkBal(0, 4, "balDrained");
        applyStimulus(4'b0011, 8, 1, 0, 0, 1, g, gc, tm);
        checkOutput("poorLoses", int'(g), 4'b0010);
        applyStimulus(4'b0001, 8, 0, 0, 0, 1, g, gc, tm);
        checkOutput("loneGrant", int'(g), 4'b0001);
        checkBal(0, 0, "balSaturatedZero");

        applyStimulus(4'b0100, 0, 0, 3, 0, 0, g, gc, tm);
        checkOutput("timeoutHoldLen", gc, MAX_HOLD);
        checkOutput("timeoutCount", tm, 1);
        step();
        checkOutput("timeoutOneCycle", int'(timeout), 0);
        applyStimulus(4'b0100, 0, 0, 3, 0, MAX_HOLD, g, gc, tm);
        checkOutput("doneAtLimitHoldLen", gc, MAX_HOLD);
        checkOutput("doneAtLimitNoTimeout", tm, 0);

        for (int n = 0; n < 30; n++) begin
            applyStimulus(4'($urandom_range(1, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, MAX_HOLD + 2)),
                          g, gc, tm);
        end

        applyReset();
        for (int n = 0; n < 3000 && mBal[0] < 1008; n++) step();
        checkBal(0, 1008, "balPreSaturate");
        repeat (REFILL_PERIOD) step();
        for (int s = 0; s < 4; s++) checkBal(s, BAL_TOP, "balSaturatedTop");

        applyReset();
        req   = 4'b0010;
        bid_1 = BID_W'(5);
        step();
        req = '0;
        step();
        checkOutput("grantBeforeRst", int'(grant), 4'b0010);
        step();
        #2;
        rst = 1'b1;
        #1;
        checkOutput("grantAsyncRst", int'(grant), 0);
        checkOutput("grantValidAsyncRst", int'(grant_valid), 0);
        for (int s = 0; s < 4; s++) checkBal(s, INIT_BAL, "balAsyncRst");
        @(negedge clk);
        modelReset();
        rst = 1'b0;
        applyStimulus(4'b0001, 5, 0, 0, 0, 1, g, gc, tm);
        checkOutput("postRstGrant", int'(g), 4'b0001);
        checkBal(0, 507, "postRstBal");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bid_auction_scheduler.md
# bid_auction_scheduler

Registered, FSM-sequenced auction scheduler sharing one downstream resource among four bidding requesters. Each round it samples requests and bids, resolves one winner using per-requester credit balances, starvation aging and round-robin tie-break, then holds the grant until the winner signals completion or a hold limit expires. It owns the credit balances (debit on win, periodic refill), so the surrounding design needs no separate balance bank. It sits between the requesting masters and the shared resource.

## Interface
- BID_W, 4, bid width
- BAL_W, 10, balance width
- INIT_BAL, 512, balance value after reset
- REFILL_PERIOD, 64, cycles between refills (≥2)
- REFILL_AMT, 16, credit added per refill
- AGE_LIMIT, 32, lost rounds before a requester is starving (≤63)
- MAX_HOLD, 16, maximum grant duration in cycles (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset rst, asynchronous, active-high
- req  in  4  request per requester, level
- bid_0..bid_3  in  BID_W each  bid per requester; sampled with req
- done  in  1  winner releases resource; honoured only in GRANT
- bal_sel  in  2  balance readout select
- grant  out  4  one-hot grant, registered
- grant_valid  out  1  OR of grant
- timeout  out  1  one-cycle pulse on forced release
- starving  out  4  age[i] ≥ AGE_LIMIT
- bal_out  out  BAL_W  balance[bal_sel], combinational read of register

## Operation
- States: IDLE, RESOLVE, GRANT. Reset state IDLE.
- IDLE: if req≠0, latch req_l=req and bid_l[i]=req[i]?bid_i:0, go RESOLVE; else stay.
- RESOLVE (always 1 cycle), winner chosen in priority order:
  - 1. Starvation: any latched requester with age ≥ AGE_LIMIT → pick largest age; ties by round-robin.
  - 2. Eligible set E = {i : req_l[i] and balance[i] ≥ bid_l[i]}. If E≠∅ → highest bid in E; ties by round-robin.
  - 3. E=∅ and exactly one requester → grant it anyway (debit saturates at 0).
  - 4. Otherwise no winner → back to IDLE, grant stays 0, every latched requester counts as losing.
  - Round-robin: search starts at index (last_winner+1) mod 4; last_winner resets to 3, so slave 0 wins first ties.
  - With a winner: register grant one-hot, go GRANT, debit balance[w] by bid_l[w], set last_winner=w.
- GRANT: hold grant; hold counter increments each cycle. On done, or when the counter reaches MAX_HOLD, clear grant and go IDLE. The forced case pulses timeout for that one cycle. done and timeout together count as done: no timeout pulse.
- Aging, 6-bit saturating, updated on RESOLVE exit: winner age←0; latched losers age+1; non-requesters age←0.
- Refill: free-running counter; on every REFILL_PERIOD-th cycle each balance += REFILL_AMT.
- Arithmetic: next_bal = clamp(bal + refill_i − debit_i, 0, 2^BAL_W−1), computed BAL_W+2 bits wide. Simultaneous refill and debit are both applied in the same cycle.
- Reset values: grant=0, grant_valid=0, timeout=0, starving=0, balances=INIT_BAL, ages=0, refill/hold counters=0.

## Timing
- req sampled in IDLE at edge N; RESOLVE at N+1; grant visible after edge N+2. Latency is 2 cycles.
- Balance debit is visible on bal_out in the same cycle grant rises.
- done high at cycle M in GRANT → grant low after edge M+1, state IDLE. A new req sampled at M+1 yields a grant at M+3.
- Maximum grant length is MAX_HOLD cycles. timeout is high in the first cycle grant is low.
- req or bid changes during RESOLVE/GRANT are ignored until the next IDLE sample.
- Reset asserted mid-GRANT clears grant asynchronously; no debit or age update occurs for the aborted round.

## Test plan
- Reset, then req=0001, bid_0=5 → grant=0001 two cycles later; bal_out(sel 0)=507; done → grant=0000 next cycle.
- req=1111, bids 3/9/9/2, all balances 512 → grant=0010 (tie 1 vs 2, last_winner=3 → index 1); repeat identical round → grant=0100.
- Balance_0 drained to 4, req=0011, bid_0=8, bid_1=1 → grant=0010. Then req=0001 alone, bid_0=8 → grant=0001 and balance_0=0 (saturated).
- Requester 3 bids 1 against requester 0 bidding 15 for 32 rounds → starving[3]=1; next round grant=1000, age_3 cleared.
- Grant held with done=0 for 16 cycles → grant drops and timeout pulses once; done asserted in that same cycle → no timeout pulse.
- Set balance near max (1020), run REFILL_PERIOD idle cycles → bal_out=1023 (saturated). Assert rst mid-GRANT → grant=0 immediately and balances=512.
